// File: rtl/checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : checker_pkg
//  Description : Shared definitions for the checker control interface:
//                channel state encoding, checker mode constants, CSR
//                register offsets and the global page index.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } chan_state_t;

  localparam logic [1:0] CHECKER_MODE_SINGLE    = 2'b00;
  localparam logic [1:0] CHECKER_MODE_BURST     = 2'b01;
  localparam logic [1:0] CHECKER_MODE_ALTERNATE = 2'b10;
  localparam logic [1:0] CHECKER_MODE_STRIDE    = 2'b11;

  // Channel page register offsets
  localparam logic [5:0] REG_ADDR_LO = 6'd0;
  localparam logic [5:0] REG_ADDR_HI = 6'd1;
  localparam logic [5:0] REG_STAT    = 6'd2;
  localparam logic [5:0] REG_CTRL    = 6'd3;
  localparam logic [5:0] REG_DATA_LO = 6'd4;
  localparam logic [5:0] REG_DATA_HI = 6'd5;
  localparam logic [5:0] REG_TIMEOUT = 6'd6;

  // Global page register offsets
  localparam logic [5:0] REG_PENDING = 6'd0;
  localparam logic [5:0] REG_ID      = 6'd1;

  localparam logic [3:0]  PAGE_GLOBAL      = 4'd15;
  localparam logic [15:0] CHECKER_ID_MAGIC = 16'hC4EC;

endpackage
`default_nettype wire

// File: rtl/checker_mctlif_chan.sv
`default_nettype none
// ============================================================================
//  Module      : checker_mctlif_chan
//  Description : One checker channel: run/wait/ack state machine, ADDR /
//                CTRL / STAT / TIMEOUT registers and optional watchdog.
//                Watchdog is built only when CHECKER_MCTLIF_TIMEOUT_EN is
//                defined.
//  Ports       : clk, rst_n (sync, active-low); we/reg_a/di = write strobe,
//                register offset and data already decoded for this channel;
//                rdata = combinational read value of reg_a; mode_* = engine
//                side; pending = any enabled event flag set.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module checker_mctlif_chan
  import checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [5:0]  reg_a,
  input  logic [31:0] di,
  output logic [31:0] rdata,
  output logic [1:0]  mode_mode,
  output logic        mode_start,
  output logic [63:0] mode_addr,
  input  logic        mode_end,
  input  logic        mode_error,
  input  logic        mode_irq,
  input  logic [63:0] mode_data,
  output logic        mode_ack,
  output logic        pending
);

  chan_state_t state, state_next;
  logic [63:0] addr;
  logic [1:0]  mode;
  logic        irq_en;
  logic        flag_end, flag_error, flag_irq, flag_timeout;
  logic        set_end, set_error, set_irq, set_timeout, stop_clr_irq;
  logic        timed_out;
  logic [31:0] timeout_rd;
  logic        idle, wr_ctrl, wr_stat;
  logic [3:0]  clr;

  assign idle    = (state == ST_IDLE);
  assign wr_ctrl = we && (reg_a == REG_CTRL);
  assign wr_stat = we && (reg_a == REG_STAT);
  // Flag clears are only honoured while the engine is not actively running.
  assign clr     = (wr_stat && (idle || state == ST_WAIT)) ? di[3:0] : 4'b0;

  always_comb begin
    state_next   = state;
    set_end      = 1'b0;
    set_error    = 1'b0;
    set_irq      = 1'b0;
    set_timeout  = 1'b0;
    stop_clr_irq = 1'b0;
    case (state)
      ST_IDLE: if (wr_ctrl && di[3]) state_next = ST_RUN;
      ST_RUN: begin
        // Exit priority: end > user stop > error > timeout > irq request
        if (mode_end) begin
          state_next = ST_IDLE;
          set_end    = 1'b1;
        end else if (wr_ctrl && !di[3]) begin
          state_next = ST_IDLE;
        end else if (mode_error) begin
          state_next = ST_IDLE;
          set_error  = 1'b1;
        end else if (timed_out) begin
          state_next  = ST_IDLE;
          set_timeout = 1'b1;
        end else if (mode_irq) begin
          state_next = ST_WAIT;
          set_irq    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wr_ctrl && !di[3]) begin
          state_next   = ST_IDLE;
          stop_clr_irq = 1'b1;
        end else if (clr[2]) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= 64'b0;
      mode       <= CHECKER_MODE_SINGLE;
      irq_en     <= 1'b0;
      flag_end   <= 1'b0;
      flag_error <= 1'b0;
      flag_irq   <= 1'b0;
    end else begin
      state <= state_next;
      if (we && idle) begin
        case (reg_a)
          REG_ADDR_LO: addr[31:0]  <= di;
          REG_ADDR_HI: addr[63:32] <= di;
          REG_CTRL: begin
            mode   <= di[2:1];
            irq_en <= di[0];
          end
          default: ;
        endcase
      end
      // A set in the same cycle as a clear wins.
      flag_end   <= (flag_end & ~clr[0]) | set_end;
      flag_error <= (flag_error & ~clr[1]) | set_error;
      flag_irq   <= (flag_irq & ~clr[2] & ~stop_clr_irq) | set_irq;
    end
  end

`ifdef CHECKER_MCTLIF_TIMEOUT_EN
  logic [31:0] tmo_limit, tmo_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_limit    <= 32'hFFFF_FFFF;
      tmo_count    <= 32'b0;
      flag_timeout <= 1'b0;
    end else begin
      if (we && reg_a == REG_TIMEOUT) tmo_limit <= di;
      // Restart only on a fresh start; a WAIT/ACK excursion keeps the count.
      if (idle && state_next == ST_RUN)
        tmo_count <= 32'b0;
      else if (state == ST_RUN && tmo_count != 32'hFFFF_FFFF)
        tmo_count <= tmo_count + 32'd1;
      flag_timeout <= (flag_timeout & ~clr[3]) | set_timeout;
    end
  end

  assign timed_out  = (tmo_count == tmo_limit);
  assign timeout_rd = tmo_limit;
`else
  assign timed_out    = 1'b0;
  assign timeout_rd   = 32'b0;
  assign flag_timeout = 1'b0;
`endif

  always_comb begin
    rdata = 32'b0;
    case (reg_a)
      REG_ADDR_LO: rdata = addr[31:0];
      REG_ADDR_HI: rdata = addr[63:32];
      REG_STAT:    rdata = {28'b0, flag_timeout, flag_irq, flag_error, flag_end};
      REG_CTRL:    rdata = {27'b0, !idle, mode, irq_en};
      REG_DATA_LO: rdata = mode_data[31:0];
      REG_DATA_HI: rdata = mode_data[63:32];
      REG_TIMEOUT: rdata = timeout_rd;
      default:     rdata = 32'b0;
    endcase
  end

  assign mode_mode  = mode;
  assign mode_start = !idle;
  assign mode_addr  = addr;
  assign mode_ack   = (state == ST_ACK);
  assign pending    = irq_en && (flag_end || flag_error || flag_irq || flag_timeout);

endmodule
`default_nettype wire

// File: rtl/checker_mctlif.sv
`default_nettype none
// ============================================================================
//  Module      : checker_mctlif
//  Description : Multi-channel checker control interface. NCHAN channels
//                behind one CSR window plus a global page (PENDING, ID) and
//                an aggregated interrupt. Optional per-channel watchdog is
//                enabled by defining CHECKER_MCTLIF_TIMEOUT_EN.
//  Ports       : sys_clk, sys_rst_n (sync, active-low); csr_a/csr_we/csr_di/
//                csr_do = CSR bus (1-cycle registered read); mode_* = packed
//                per-channel engine interface; irq = OR of pending channels.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module checker_mctlif
  import checker_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         NCHAN    = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [13:0]           csr_a,
  input  logic                  csr_we,
  input  logic [31:0]           csr_di,
  output logic [31:0]           csr_do,
  output logic [2*NCHAN-1:0]    mode_mode,
  output logic [NCHAN-1:0]      mode_start,
  output logic [64*NCHAN-1:0]   mode_addr,
  input  logic [NCHAN-1:0]      mode_end,
  input  logic [NCHAN-1:0]      mode_error,
  input  logic [NCHAN-1:0]      mode_irq,
  input  logic [64*NCHAN-1:0]   mode_data,
  output logic [NCHAN-1:0]      mode_ack,
  output logic                  irq
);

  logic             sel;
  logic [3:0]       page;
  logic [5:0]       reg_a;
  logic [NCHAN-1:0] pending;
  logic [31:0]      chan_rdata [NCHAN];
  logic [31:0]      rd_next;

  assign sel   = (csr_a[13:10] == csr_addr);
  assign page  = csr_a[9:6];
  assign reg_a = csr_a[5:0];

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    checker_mctlif_chan u_chan (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .we         (csr_we && sel && (page == 4'(i))),
      .reg_a      (reg_a),
      .di         (csr_di),
      .rdata      (chan_rdata[i]),
      .mode_mode  (mode_mode[2*i +: 2]),
      .mode_start (mode_start[i]),
      .mode_addr  (mode_addr[64*i +: 64]),
      .mode_end   (mode_end[i]),
      .mode_error (mode_error[i]),
      .mode_irq   (mode_irq[i]),
      .mode_data  (mode_data[64*i +: 64]),
      .mode_ack   (mode_ack[i]),
      .pending    (pending[i])
    );
  end

  // Pages that map to no channel and are not global fall through to 0.
  always_comb begin
    rd_next = 32'b0;
    if (sel) begin
      if (page == PAGE_GLOBAL) begin
        case (reg_a)
          REG_PENDING: rd_next = 32'(pending);
          REG_ID:      rd_next = {CHECKER_ID_MAGIC, 12'b0, 4'(NCHAN)};
          default:     rd_next = 32'b0;
        endcase
      end else begin
        for (int i = 0; i < NCHAN; i++)
          if (page == 4'(i)) rd_next = chan_rdata[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) csr_do <= 32'b0;
    else            csr_do <= rd_next;
  end

  assign irq = |pending;

endmodule
`default_nettype wire

// File: tb/tb_checker_mctlif.sv
`default_nettype none
// ============================================================================
//  Module      : tb_checker_mctlif
//  Description : Self-checking bench for checker_mctlif (NCHAN = 4). A
//                behavioural per-channel model predicts every output each
//                cycle; directed sequences add fixed-value checks. Follows
//                CHECKER_MCTLIF_TIMEOUT_EN the same way as the design.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
`timescale 1ns/1ps
module tb_checker_mctlif;

  localparam int NCHAN = 4;
`ifdef CHECKER_MCTLIF_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic [13:0]         csr_a;
  logic                csr_we;
  logic [31:0]         csr_di;
  logic [31:0]         csr_do;
  logic [2*NCHAN-1:0]  mode_mode;
  logic [NCHAN-1:0]    mode_start;
  logic [64*NCHAN-1:0] mode_addr;
  logic [NCHAN-1:0]    mode_end, mode_error, mode_irq;
  logic [64*NCHAN-1:0] mode_data;
  logic [NCHAN-1:0]    mode_ack;
  logic                irq;

  always #5 sys_clk = ~sys_clk;

  checker_mctlif #(.csr_addr(4'h0), .NCHAN(NCHAN)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .mode_mode  (mode_mode),
    .mode_start (mode_start),
    .mode_addr  (mode_addr),
    .mode_end   (mode_end),
    .mode_error (mode_error),
    .mode_irq   (mode_irq),
    .mode_data  (mode_data),
    .mode_ack   (mode_ack),
    .irq        (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run [NCHAN];
  bit          m_wait[NCHAN];
  bit          m_ack [NCHAN];
  logic [63:0] m_addr[NCHAN];
  logic [1:0]  m_mode[NCHAN];
  bit          m_ien [NCHAN];
  logic [3:0]  m_flags[NCHAN];
  logic [31:0] m_lim [NCHAN];
  logic [31:0] m_cnt [NCHAN];
  logic [31:0] exp_do;

  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      m_run[c] = 0; m_wait[c] = 0; m_ack[c] = 0;
      m_addr[c] = '0; m_mode[c] = 2'b00; m_ien[c] = 0;
      m_flags[c] = 4'h0; m_lim[c] = 32'hFFFF_FFFF; m_cnt[c] = 32'h0;
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = 32'h0;
    for (int c = 0; c < NCHAN; c++)
      p[c] = m_ien[c] && (m_flags[c] != 4'h0);
    return p;
  endfunction

  function automatic logic [31:0] model_read(input logic [13:0] a);
    int p = int'(a[9:6]);
    int r = int'(a[5:0]);
    if (a[13:10] != 4'h0) return 32'h0;
    if (p == 15) begin
      if (r == 0) return m_pending();
      if (r == 1) return 32'hC4EC_0000 + NCHAN;
      return 32'h0;
    end
    if (p >= NCHAN) return 32'h0;
    case (r)
      0: return m_addr[p][31:0];
      1: return m_addr[p][63:32];
      2: return {28'h0, m_flags[p]};
      3: return {27'h0, (m_run[p] | m_wait[p] | m_ack[p]), m_mode[p], m_ien[p]};
      4: return mode_data[64*p +: 32];
      5: return mode_data[64*p+32 +: 32];
      6: return TMO ? m_lim[p] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCHAN; c++) begin
      bit         we_c, busy, start_w, stop_w;
      int         r;
      logic [3:0] clr, setf;
      we_c    = csr_we && (csr_a[13:10] == 4'h0) && (int'(csr_a[9:6]) == c);
      r       = int'(csr_a[5:0]);
      busy    = m_run[c] | m_wait[c] | m_ack[c];
      start_w = we_c && r == 3 && csr_di[3];
      stop_w  = we_c && r == 3 && !csr_di[3];
      clr     = (we_c && r == 2 && (!busy || m_wait[c])) ? csr_di[3:0] : 4'h0;
      setf    = 4'h0;
      if (we_c && !busy) begin
        if (r == 0) m_addr[c][31:0]  = csr_di;
        if (r == 1) m_addr[c][63:32] = csr_di;
        if (r == 3) begin m_mode[c] = csr_di[2:1]; m_ien[c] = csr_di[0]; end
      end
      if (we_c && r == 6 && TMO) m_lim[c] = csr_di;
      if (!busy) begin
        if (start_w) begin m_run[c] = 1; m_cnt[c] = 32'h0; end
      end else if (m_run[c]) begin
        if (mode_end[c])                        begin m_run[c] = 0; setf[0] = 1; end
        else if (stop_w)                              m_run[c] = 0;
        else if (mode_error[c])                 begin m_run[c] = 0; setf[1] = 1; end
        else if (TMO && m_cnt[c] == m_lim[c])   begin m_run[c] = 0; setf[3] = 1; end
        else if (mode_irq[c])      begin m_run[c] = 0; m_wait[c] = 1; setf[2] = 1; end
        if (m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] = m_cnt[c] + 1;
      end else if (m_wait[c]) begin
        if (stop_w)       begin m_wait[c] = 0; clr[2] = 1; end
        else if (clr[2])  begin m_wait[c] = 0; m_ack[c] = 1; end
      end else begin
        m_ack[c] = 0; m_run[c] = 1;
      end
      m_flags[c] = (m_flags[c] & ~clr) | setf;
    end
  endtask

  task automatic check_outputs();
    check("csr_do", csr_do, exp_do);
    check("irq", irq, m_pending() != 0);
    for (int c = 0; c < NCHAN; c++) begin
      check($sformatf("mode_start[%0d]", c), mode_start[c], m_run[c] | m_wait[c] | m_ack[c]);
      check($sformatf("mode_ack[%0d]", c), mode_ack[c], m_ack[c]);
      check($sformatf("mode_mode[%0d]", c), mode_mode[2*c +: 2], m_mode[c]);
      check($sformatf("mode_addr[%0d]", c), mode_addr[64*c +: 64], m_addr[c]);
    end
  endtask

  // One clock: model advances on the same inputs the DUT samples.
  task automatic step();
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      model_reset();
      exp_do = 32'h0;
    end else begin
      exp_do = model_read(csr_a);
      model_edge();
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [13:0] ca(input int page, input int r);
    return {4'h0, 4'(page), 6'(r)};
  endfunction

  task automatic wr(input int page, input int r, input logic [31:0] d);
    csr_a = ca(page, r); csr_we = 1'b1; csr_di = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input int page, input int r);
    csr_a = ca(page, r); csr_we = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    sys_rst_n = 1'b0; csr_a = '0; csr_we = 1'b0; csr_di = '0;
    mode_end = '0; mode_error = '0; mode_irq = '0;
    for (int c = 0; c < 2*NCHAN; c++) mode_data[32*c +: 32] = $urandom;
    model_reset();
    exp_do = 32'h0;
    step(); step();
    sys_rst_n = 1'b1;

    // Reset values
    rd(15, 1); check("id", csr_do, 32'hC4EC_0004);
    for (int c = 0; c < NCHAN; c++) begin
      rd(c, 3); check("ctrl_rst", csr_do, 32'h0);
    end
    rd(0, 6); check("timeout_rst", csr_do, TMO ? 32'hFFFF_FFFF : 32'h0);

    // Channel 2: address, start, end event, interrupt, clear
    wr(2, 0, 32'h0000_2000); wr(2, 1, 32'h1);
    check("addr2", mode_addr[128 +: 64], 64'h1_0000_2000);
    wr(2, 3, 32'h9); check("start2", mode_start[2], 1'b1);
    mode_end = 4'b0100; step(); mode_end = '0;
    check("end_stop2", mode_start[2], 1'b0);
    check("irq_end2", irq, 1'b1);
    rd(2, 2);  check("stat2", csr_do, 32'h1);
    rd(15, 0); check("pending", csr_do, 32'h4);
    wr(2, 2, 32'h1); check("irq_clr", irq, 1'b0);

    // Channel 0: irq request, wait, ack handshake, address lock while busy
    wr(0, 3, 32'h8);
    wr(0, 0, 32'hDEAD); check("addr0_locked", mode_addr[63:0], 64'h0);
    mode_irq = 4'b0001; step(); mode_irq = '0;
    rd(0, 2); check("stat0", csr_do, 32'h4);
    wr(0, 2, 32'h4); check("ack_hi", mode_ack[0], 1'b1);
    step(); check("ack_lo", mode_ack[0], 1'b0); check("run_resume", mode_start[0], 1'b1);
    wr(0, 3, 32'h0);

    // Channel 3: watchdog
    wr(3, 6, 32'd10); wr(3, 3, 32'h8);
    repeat (10) step();
    check("wd_still", mode_start[3], 1'b1);
    step(); check("wd_abort", mode_start[3], TMO ? 1'b0 : 1'b1);
    rd(3, 2); check("stat3", csr_do, TMO ? 32'h8 : 32'h0);
    wr(3, 3, 32'h0);

    // Channel 1: end and user stop in the same cycle
    wr(1, 3, 32'h8);
    csr_a = ca(1, 3); csr_we = 1'b1; csr_di = 32'h0; mode_end = 4'b0010;
    step();
    csr_we = 1'b0; mode_end = '0;
    rd(1, 2); check("end_wins", csr_do[0], 1'b1);

    // Reset while running with an interrupt pending
    wr(2, 3, 32'h9); mode_error = 4'b0100; step(); mode_error = '0;
    wr(0, 3, 32'h8); rd(15, 1);
    sys_rst_n = 1'b0; step();
    check("rst_start", mode_start, 4'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_do", csr_do, 32'h0);
    sys_rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int p, r, sel;
      for (int c = 0; c < NCHAN; c++) begin
        mode_end[c]   = ($urandom_range(0, 19) == 0);
        mode_error[c] = ($urandom_range(0, 29) == 0);
        mode_irq[c]   = ($urandom_range(0, 14) == 0);
      end
      for (int c = 0; c < 2*NCHAN; c++) mode_data[32*c +: 32] = $urandom;
      sys_rst_n = ($urandom_range(0, 299) != 0);
      sel = $urandom_range(0, 5);
      if (sel < 4)       p = sel;
      else if (sel == 4) p = 15;
      else               p = $urandom_range(4, 14);
      r = $urandom_range(0, 7);
      csr_a  = {($urandom_range(0, 9) == 0) ? 4'h1 : 4'h0, 4'(p), 6'(r)};
      csr_we = ($urandom_range(0, 2) == 0);
      csr_di = $urandom;
      if (r == 6) csr_di = $urandom_range(0, 25);
      if (r == 3) csr_di = {28'h0, ($urandom_range(0, 2) != 0), 3'($urandom)};
      step();
    end

    sys_rst_n = 1'b1; csr_we = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
